// File: rtl/exc_controller.sv
// Exception controller: latches level IRQs into a pending set and arbitrates
// invalid-opcode and IRQ causes into a single request/acknowledge/return handshake.
module exc_controller #(
  parameter int N_IRQ     = 4,
  parameter int ESTATUS_W = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [N_IRQ-1:0]                              ExtIRQ,
  input  logic [N_IRQ-1:0]                              IrqMask,
  input  logic                                          NotAnInstr,
  input  logic                                          ERet,
  input  logic                                          ExcAck,
  output logic                                          Exc,
  output logic [ESTATUS_W-1:0]                          EStatus,
  output logic [$clog2((N_IRQ > 1) ? N_IRQ : 2)-1:0]    IrqId,
  output logic [N_IRQ-1:0]                              ExtIAck,
  output logic                                          InHandler
);

  localparam int IW = $clog2((N_IRQ > 1) ? N_IRQ : 2);

  localparam logic SRC_INSTR = 1'b0;
  localparam logic SRC_IRQ   = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_REQ     = 2'b01,
    S_HANDLER = 2'b10
  } state_t;

  state_t                 r_state;
  logic                   r_src;
  logic [ESTATUS_W-1:0]   r_estatus;
  logic [IW-1:0]          r_irq_id;
  logic [N_IRQ-1:0]       r_pend;
  logic [N_IRQ-1:0]       r_ext_iack;
  logic [N_IRQ-1:0]       w_eligible;
  logic [N_IRQ-1:0]       w_clr;
  logic [IW-1:0]          w_low_idx;
  logic                   w_any_eligible;

  function automatic logic [IW-1:0] lowest_index(input logic [N_IRQ-1:0] vec);
    logic [IW-1:0] idx;
    idx = {IW{1'b0}};
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IW'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [N_IRQ-1:0] one_hot(input logic [IW-1:0] idx);
    logic [N_IRQ-1:0] vec;
    for (int i = 0; i < N_IRQ; i++) begin
      vec[i] = (idx == IW'(i));
    end
    return vec;
  endfunction

  // The acknowledge pulse doubles as the pending-bit clear for that channel.
  assign w_clr          = r_ext_iack;
  assign w_eligible     = r_pend & IrqMask;
  assign w_any_eligible = |w_eligible;
  assign w_low_idx      = lowest_index(w_eligible);

  // Pending latch: a new request in the clear cycle keeps the bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= {N_IRQ{1'b0}};
    end else begin
      r_pend <= ExtIRQ | (r_pend & ~w_clr);
    end
  end

  // Exception sequencing FSM with captured cause and acknowledge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_src      <= SRC_INSTR;
      r_estatus  <= {ESTATUS_W{1'b0}};
      r_irq_id   <= {IW{1'b0}};
      r_ext_iack <= {N_IRQ{1'b0}};
    end else begin
      r_ext_iack <= {N_IRQ{1'b0}};
      case (r_state)
        S_IDLE: begin
          if (NotAnInstr) begin
            r_state   <= S_REQ;
            r_src     <= SRC_INSTR;
            r_estatus <= ESTATUS_W'(4'b0010);
            r_irq_id  <= {IW{1'b0}};
          end else if (w_any_eligible) begin
            r_state   <= S_REQ;
            r_src     <= SRC_IRQ;
            r_estatus <= ESTATUS_W'(4'b0001);
            r_irq_id  <= w_low_idx;
          end else begin
            r_state   <= S_IDLE;
          end
        end
        S_REQ: begin
          if (ExcAck) begin
            r_state <= S_HANDLER;
            if (r_src == SRC_IRQ) begin
              r_ext_iack <= one_hot(r_irq_id);
            end else begin
              r_ext_iack <= {N_IRQ{1'b0}};
            end
          end else begin
            r_state <= S_REQ;
          end
        end
        S_HANDLER: begin
          if (ERet) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_HANDLER;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Exc       = (r_state == S_REQ);
  assign InHandler = (r_state == S_HANDLER);
  assign EStatus   = r_estatus;
  assign IrqId     = r_irq_id;
  assign ExtIAck   = r_ext_iack;

endmodule

// File: tb/tb_exc_controller.sv
// Self-checking bench for exc_controller: directed vector table, corner sequences,
// and randomized traffic compared against a cycle-level reference model.
module tb_exc_controller;

  localparam int N  = 4;
  localparam int EW = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] ext_irq;
  logic [N-1:0] irq_mask;
  logic         nai;
  logic         eret;
  logic         exc_ack;
  logic         exc;
  logic [EW-1:0] estatus;
  logic [1:0]   irq_id;
  logic [N-1:0] ext_iack;
  logic         in_handler;

  always #5 clk = ~clk;

  exc_controller #(.N_IRQ(N), .ESTATUS_W(EW)) dut (
    .clk(clk), .reset(reset), .ExtIRQ(ext_irq), .IrqMask(irq_mask),
    .NotAnInstr(nai), .ERet(eret), .ExcAck(exc_ack), .Exc(exc),
    .EStatus(estatus), .IrqId(irq_id), .ExtIAck(ext_iack), .InHandler(in_handler)
  );

  typedef struct {
    logic       rst;
    logic [3:0] ext;
    logic [3:0] mask;
    logic       n;
    logic       e;
    logic       a;
    logic       x_exc;
    logic [3:0] x_es;
    logic [1:0] x_id;
    logic [3:0] x_iack;
    logic       x_inh;
  } vec_t;

  vec_t tbl[26];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model: mode 0=idle 1=req 2=handler; m_iack = channel being acked or -1
  int m_mode = 0;
  bit m_pend[N];
  int m_es = 0;
  int m_id = 0;
  bit m_src_irq = 0;
  int m_iack = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int  nxt_iack = -1;
    int  cand = -1;
    bit  new_pend[N];
    if (reset) begin
      m_mode = 0; m_es = 0; m_id = 0; m_src_irq = 0; m_iack = -1;
      for (int i = 0; i < N; i++) m_pend[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) new_pend[i] = ext_irq[i] || (m_pend[i] && (i != m_iack));
      if (m_mode == 0) begin
        for (int i = N - 1; i >= 0; i--) if (m_pend[i] && irq_mask[i]) cand = i;
        if (nai) begin
          m_mode = 1; m_es = 2; m_id = 0; m_src_irq = 0;
        end else if (cand >= 0) begin
          m_mode = 1; m_es = 1; m_id = cand; m_src_irq = 1;
        end
      end else if (m_mode == 1) begin
        if (exc_ack) begin
          m_mode = 2;
          if (m_src_irq) nxt_iack = m_id;
        end
      end else begin
        if (eret) m_mode = 0;
      end
      for (int i = 0; i < N; i++) m_pend[i] = new_pend[i];
      m_iack = nxt_iack;
    end
  endtask

  task automatic check_model(input int cyc);
    check($sformatf("rnd%0d exc", cyc), 32'(exc), 32'(m_mode == 1));
    check($sformatf("rnd%0d inh", cyc), 32'(in_handler), 32'(m_mode == 2));
    check($sformatf("rnd%0d es", cyc), 32'(estatus), 32'(m_es));
    check($sformatf("rnd%0d id", cyc), 32'(irq_id), 32'(m_id));
    check($sformatf("rnd%0d iack", cyc), 32'(ext_iack), (m_iack >= 0) ? (32'd1 << m_iack) : 32'd0);
  endtask

  task automatic apply(input logic rst, input logic [3:0] ext, input logic [3:0] mask,
                       input logic n, input logic e, input logic a);
    reset = rst; ext_irq = ext; irq_mask = mask; nai = n; eret = e; exc_ack = a;
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    reset = 1'b1; ext_irq = 4'h0; irq_mask = 4'h0; nai = 1'b0; eret = 1'b0; exc_ack = 1'b0;

    //           rst   ext   mask  nai   eret  ack   exc   es    id    iack  inh
    tbl[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 4'h0, 1'b0};
    tbl[1]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 2'd0, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 2'd0, 4'h0, 1'b1};
    tbl[4]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 2'd0, 4'h0, 1'b1};
    tbl[5]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 2'd0, 4'h0, 1'b0};
    tbl[6]  = '{1'b0, 4'h6, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 2'd0, 4'h0, 1'b0};
    tbl[7]  = '{1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 2'd1, 4'h0, 1'b0};
    tbl[8]  = '{1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 2'd1, 4'h2, 1'b1};
    tbl[9]  = '{1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 2'd1, 4'h0, 1'b1};
    tbl[10] = '{1'b0, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 2'd1, 4'h0, 1'b0};
    tbl[11] = '{1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 2'd2, 4'h0, 1'b0};
    tbl[12] = '{1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 2'd2, 4'h4, 1'b1};
    tbl[13] = '{1'b0, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 2'd2, 4'h0, 1'b0};
    tbl[14] = '{1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 2'd2, 4'h0, 1'b0};
    tbl[15] = '{1'b0, 4'h1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 2'd0, 4'h0, 1'b0};
    tbl[16] = '{1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 2'd0, 4'h0, 1'b1};
    tbl[17] = '{1'b0, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 2'd0, 4'h0, 1'b0};
    tbl[18] = '{1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 2'd0, 4'h0, 1'b0};
    tbl[19] = '{1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 2'd0, 4'h1, 1'b1};
    tbl[20] = '{1'b0, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 2'd0, 4'h0, 1'b0};
    tbl[21] = '{1'b0, 4'h8, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 2'd0, 4'h0, 1'b0};
    tbl[22] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 2'd0, 4'h0, 1'b0};
    tbl[23] = '{1'b0, 4'h0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 2'd3, 4'h0, 1'b0};
    tbl[24] = '{1'b0, 4'h0, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 2'd3, 4'h8, 1'b1};
    tbl[25] = '{1'b0, 4'h0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 2'd3, 4'h0, 1'b0};

    for (int i = 0; i < 26; i++) begin
      apply(tbl[i].rst, tbl[i].ext, tbl[i].mask, tbl[i].n, tbl[i].e, tbl[i].a);
      check($sformatf("row%0d exc", i), 32'(exc), 32'(tbl[i].x_exc));
      check($sformatf("row%0d es", i), 32'(estatus), 32'(tbl[i].x_es));
      check($sformatf("row%0d id", i), 32'(irq_id), 32'(tbl[i].x_id));
      check($sformatf("row%0d iack", i), 32'(ext_iack), 32'(tbl[i].x_iack));
      check($sformatf("row%0d inh", i), 32'(in_handler), 32'(tbl[i].x_inh));
    end

    // reset while in REQ (with ExcAck) and while in HANDLER
    apply(1'b0, 4'h4, 4'hF, 1'b0, 1'b0, 1'b0);
    check("rstreq idle", 32'(exc), 32'd0);
    apply(1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    check("rstreq exc", 32'(exc), 32'd1);
    check("rstreq id", 32'(irq_id), 32'd2);
    apply(1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 1'b1);
    check("rstreq exc0", 32'(exc), 32'd0);
    check("rstreq inh0", 32'(in_handler), 32'd0);
    check("rstreq es0", 32'(estatus), 32'd0);
    check("rstreq id0", 32'(irq_id), 32'd0);
    check("rstreq iack0", 32'(ext_iack), 32'd0);
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
      check($sformatf("rstreq after%0d exc", k), 32'(exc), 32'd0);
      check($sformatf("rstreq after%0d iack", k), 32'(ext_iack), 32'd0);
    end
    apply(1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b1);
    check("rsthdl inh", 32'(in_handler), 32'd1);
    apply(1'b1, 4'h2, 4'hF, 1'b0, 1'b0, 1'b0);
    check("rsthdl inh0", 32'(in_handler), 32'd0);
    check("rsthdl exc0", 32'(exc), 32'd0);
    check("rsthdl es0", 32'(estatus), 32'd0);
    apply(1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    check("rsthdl pend0", 32'(exc), 32'd0);

    // ERet outside HANDLER is ignored; ExcAck held 3 cycles gives one pulse
    apply(1'b0, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0);
    check("eret idle exc", 32'(exc), 32'd0);
    check("eret idle inh", 32'(in_handler), 32'd0);
    apply(1'b0, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0);
    check("eret req exc", 32'(exc), 32'd1);
    check("eret req es", 32'(estatus), 32'd1);
    apply(1'b0, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0);
    check("eret inreq exc", 32'(exc), 32'd1);
    check("eret inreq inh", 32'(in_handler), 32'd0);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 4'h0, 4'hF, 1'b0, 1'b0, (k < 3) ? 1'b1 : 1'b0);
      if (ext_iack != 4'h0) pulses++;
      if (k == 0) check("ackhold iack", 32'(ext_iack), 32'h1);
    end
    check("ackhold pulses", 32'(pulses), 32'd1);
    check("ackhold inh", 32'(in_handler), 32'd1);

    // randomized traffic against the reference model
    apply(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_model(0);
    for (int c = 1; c < 400; c++) begin
      apply(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0);
      check_model(c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
